irq_csr_bank: RTL and testbench

//  Parametrised memory-mapped interrupt register bank. Generalises the 20-slot write-enable decoder:
//  - channel count and base address are parameters
//  - per-channel enable/mode registers, W1C pending register and claim-ID register are held here
//  - registered read-back, address-error flag and registered interrupt output

---
 rtl/irq_csr_bank_if.sv | 33 +++
 rtl/irq_csr_bank.sv | 153 +++++++++++++++
 tb/tb_irq_csr_bank.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_csr_bank_if.sv
// irq_csr_bank_if
//   Data-memory bus between the core (master) and the interrupt register
//   bank (slave).
//   wren/rden  single-cycle write/read strobes
//   addr       byte address
//   wdata      write data
//   wr_sel     combinational one-hot write select: CTRL[k] is bit k, PENDING is bit NUM_CH
//   rdata      registered read data, qualified by rvalid
//   rvalid     read-data strobe, one cycle after rden
//   addr_err   one-cycle pulse flagging an unmapped or misaligned access
interface irq_csr_bank_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_CH     = 20
);
    logic                  wren;
    logic                  rden;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic [NUM_CH:0]       wr_sel;
    logic [31:0]           rdata;
    logic                  rvalid;
    logic                  addr_err;

    modport master (
        output wren, rden, addr, wdata,
        input  wr_sel, rdata, rvalid, addr_err
    );

    modport slave (
        input  wren, rden, addr, wdata,
        output wr_sel, rdata, rvalid, addr_err
    );
endinterface

// File: rtl/irq_csr_bank.sv
// irq_csr_bank
//   Memory-mapped interrupt register bank. It holds the per-channel CTRL
//   registers (bit0 EN, bit1 MODE: 0 = rising edge, 1 = level), a
//   write-1-to-clear PENDING register and a read-only CLAIM register that
//   reports the lowest enabled pending channel. Register k sits at byte
//   offset 4*k from BASE_ADDR, PENDING at 0x80 and CLAIM at 0x84.
//   Ports:
//     clk      clock, all state changes on the rising edge
//     rst_n    asynchronous active-low reset
//     bus      slave side of irq_csr_bank_if (strobes, address, data, wr_sel,
//              registered read-back, addr_err)
//     irq_src  interrupt sources, already synchronous to clk
//     irq_o    registered interrupt request, |(PENDING & EN)
module irq_csr_bank #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0009_0000,
    parameter int                    NUM_CH     = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    irq_csr_bank_if.slave        bus,
    input  logic [NUM_CH-1:0]    irq_src,
    output logic                 irq_o
);

    localparam logic [ADDR_WIDTH-1:0] PEND_OFS  = ADDR_WIDTH'(32'h80);
    localparam logic [ADDR_WIDTH-1:0] CLAIM_OFS = ADDR_WIDTH'(32'h84);

    logic [ADDR_WIDTH-1:0] offset;
    logic                  aligned;
    logic [NUM_CH-1:0]     ctrl_hit;
    logic                  pend_hit;
    logic                  claim_hit;
    logic                  mapped;
    logic [NUM_CH:0]       wr_sel;

    logic [NUM_CH-1:0]     en_q, en_d;
    logic [NUM_CH-1:0]     mode_q, mode_d;
    logic [NUM_CH-1:0]     pend_q, pend_d;
    logic [NUM_CH-1:0]     src_q, src_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  addr_err_q, addr_err_d;
    logic                  irq_q, irq_d;

    logic [NUM_CH-1:0]     active;
    logic                  claim_valid;
    logic [4:0]            claim_id;
    logic [NUM_CH-1:0]     w1c;
    logic [NUM_CH-1:0]     edge_set;
    logic [31:0]           pend_ext;
    logic [31:0]           rd_val;

    // Address decode. An address below BASE_ADDR wraps to a large offset and
    // therefore misses every register.
    always_comb begin
        offset  = bus.addr - BASE_ADDR;
        aligned = (bus.addr[1:0] == 2'b00);
        for (int k = 0; k < NUM_CH; k++) begin
            ctrl_hit[k] = aligned && (offset == ADDR_WIDTH'(4 * k));
        end
        pend_hit  = aligned && (offset == PEND_OFS);
        claim_hit = aligned && (offset == CLAIM_OFS);
        mapped    = (|ctrl_hit) | pend_hit | claim_hit;
    end

    // CLAIM is not writable, so it never appears in the write select.
    assign wr_sel     = bus.wren ? {pend_hit, ctrl_hit} : '0;
    assign bus.wr_sel = wr_sel;

    // Lowest-index enabled pending channel; scanning downward lets the lowest
    // index overwrite any higher one.
    always_comb begin
        active      = pend_q & en_q;
        claim_valid = 1'b0;
        claim_id    = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (active[k]) begin
                claim_valid = 1'b1;
                claim_id    = 5'(k);
            end
        end
    end

    always_comb begin
        en_d   = en_q;
        mode_d = mode_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (wr_sel[k]) begin
                en_d[k]   = bus.wdata[0];
                mode_d[k] = bus.wdata[1];
            end
        end

        // Level channels track the source and ignore W1C; edge channels give
        // a new rising edge priority over a same-cycle clear. EN does not
        // gate capture.
        w1c      = wr_sel[NUM_CH] ? bus.wdata[NUM_CH-1:0] : '0;
        edge_set = irq_src & ~src_q;
        pend_d   = (mode_q & irq_src) | (~mode_q & ((pend_q & ~w1c) | edge_set));
        src_d    = irq_src;

        // Read-back uses current register state, so a same-cycle write is
        // not visible until the following read.
        pend_ext               = '0;
        pend_ext[NUM_CH-1:0]   = pend_q;
        rd_val                 = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ctrl_hit[k]) begin
                rd_val = {30'b0, mode_q[k], en_q[k]};
            end
        end
        if (pend_hit) begin
            rd_val = pend_ext;
        end
        if (claim_hit) begin
            rd_val = {claim_valid, 26'b0, claim_id};
        end

        rdata_d    = bus.rden ? rd_val : '0;
        rvalid_d   = bus.rden;
        addr_err_d = (bus.wren | bus.rden) & ~mapped;
        irq_d      = |active;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q       <= '0;
            mode_q     <= '0;
            pend_q     <= '0;
            src_q      <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            addr_err_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            en_q       <= en_d;
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            src_q      <= src_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            addr_err_q <= addr_err_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.addr_err = addr_err_q;
    assign irq_o        = irq_q;

endmodule

// File: tb/tb_irq_csr_bank.sv
// tb_irq_csr_bank
//   Directed scenarios plus a randomized run for irq_csr_bank, checked
//   against a register-level reference model of the bank held in the bench.
module tb_irq_csr_bank;

    localparam int          NCH  = 20;
    localparam logic [31:0] BASE = 32'h0009_0000;
    localparam int          RP   = 100;   // region code: PENDING
    localparam int          RC   = 101;   // region code: CLAIM

    logic           clk;
    logic           rst_n;
    logic [NCH-1:0] src;
    logic           irq_o;

    irq_csr_bank_if #(.ADDR_WIDTH(32), .NUM_CH(NCH)) bus ();

    irq_csr_bank #(.ADDR_WIDTH(32), .BASE_ADDR(BASE), .NUM_CH(NCH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .irq_src (src),
        .irq_o   (irq_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [NCH-1:0] m_en, m_mode, m_pend, m_src;
    logic [31:0]    m_rdata;
    logic           m_rvalid, m_err, m_irq;

    function automatic int region(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (a[1:0] != 2'b00) return -1;
        if (off < 4 * NCH)   return int'(off / 4);
        if (off == 32'h80)   return RP;
        if (off == 32'h84)   return RC;
        return -1;
    endfunction

    function automatic logic [NCH:0] exp_wrsel(input logic w, input logic [31:0] a);
        int r;
        logic [NCH:0] e;
        e = '0;
        r = region(a);
        if (w && r >= 0 && r < NCH) e[r] = 1'b1;
        else if (w && r == RP)      e[NCH] = 1'b1;
        return e;
    endfunction

    function automatic logic [31:0] claim_of(input logic [NCH-1:0] p, input logic [NCH-1:0] e);
        for (int k = 0; k < NCH; k++)
            if (p[k] && e[k]) return {1'b1, 26'b0, 5'(k)};
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_en = '0; m_mode = '0; m_pend = '0; m_src = '0;
        m_rdata = '0; m_rvalid = 1'b0; m_err = 1'b0; m_irq = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int             r;
        logic [31:0]    rv;
        logic [NCH-1:0] w1c, np;
        r  = region(bus.addr);
        rv = 32'h0;
        if (r >= 0 && r < NCH) rv = {30'b0, m_mode[r], m_en[r]};
        else if (r == RP)      rv = 32'(m_pend);
        else if (r == RC)      rv = claim_of(m_pend, m_en);
        m_rvalid = bus.rden;
        m_rdata  = bus.rden ? rv : 32'h0;
        m_err    = (bus.wren || bus.rden) && (r < 0);
        m_irq    = |(m_pend & m_en);
        w1c      = (bus.wren && r == RP) ? bus.wdata[NCH-1:0] : '0;
        for (int k = 0; k < NCH; k++) begin
            if (m_mode[k]) np[k] = src[k];
            else           np[k] = (m_pend[k] && !w1c[k]) || (src[k] && !m_src[k]);
        end
        m_pend = np;
        m_src  = src;
        if (bus.wren && r >= 0 && r < NCH) begin
            m_en[r]   = bus.wdata[0];
            m_mode[r] = bus.wdata[1];
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.wren = 1'b1; bus.rden = 1'b0; bus.addr = a; bus.wdata = d;
        tick();
        bus.wren = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        bus.rden = 1'b1; bus.wren = 1'b0; bus.addr = a;
        tick();
        bus.rden = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (bus.rvalid !== 1'b0 || irq_o !== 1'b0 || bus.addr_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs rvalid=%b irq=%b err=%b want 0", bus.rvalid, irq_o, bus.addr_err); end
        @(negedge clk); rst_n = 1'b1;
        // Build up state, then reset in the middle of a read
        wr(BASE, 32'h1);
        src[0] = 1'b1; tick(); src[0] = 1'b0; tick();
        n_cmp++; if (irq_o !== m_irq || irq_o !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_irq got %b want 1", irq_o); end
        rd(BASE);
        n_cmp++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h1) begin
            n_fail++; $display("FAIL pre_reset_read rvalid=%b rdata=%h want 1/00000001", bus.rvalid, bus.rdata); end
        bus.rden = 1'b1; bus.addr = BASE + 32'h80;
        rst_n = 1'b0; #1;
        bus.rden = 1'b0;
        model_reset();
        n_cmp++; if (bus.rvalid !== 1'b0 || bus.rdata !== 32'h0 || irq_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_midread rvalid=%b rdata=%h irq=%b want 0", bus.rvalid, bus.rdata, irq_o); end
        @(negedge clk); rst_n = 1'b1;
        rd(BASE);
        n_cmp++; if (bus.rdata !== 32'h0 || bus.rvalid !== 1'b1) begin
            n_fail++; $display("FAIL reset_ctrl0 rdata=%h want 0", bus.rdata); end
        rd(BASE + 32'h80);
        n_cmp++; if (bus.rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_pending rdata=%h want 0", bus.rdata); end
        rd(BASE + 32'h84);
        n_cmp++; if (bus.rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_claim rdata=%h want 0", bus.rdata); end
    endtask

    task automatic test_edge();
        wr(BASE + 32'hC, 32'h1);
        src[3] = 1'b1; tick(); src[3] = 1'b0; tick();
        n_cmp++; if (irq_o !== 1'b1) begin
            n_fail++; $display("FAIL edge_irq got %b want 1", irq_o); end
        rd(BASE + 32'h80);
        n_cmp++; if (bus.rdata !== 32'h8 || bus.rdata !== m_rdata) begin
            n_fail++; $display("FAIL edge_pending rdata=%h want 00000008", bus.rdata); end
        rd(BASE + 32'h84);
        n_cmp++; if (bus.rdata !== 32'h8000_0003) begin
            n_fail++; $display("FAIL edge_claim rdata=%h want 80000003", bus.rdata); end
    endtask

    task automatic test_w1c_race();
        bus.wren = 1'b1; bus.addr = BASE + 32'h80; bus.wdata = 32'h8; src[3] = 1'b1;
        tick();
        bus.wren = 1'b0; src[3] = 1'b0;
        rd(BASE + 32'h80);
        n_cmp++; if (bus.rdata !== 32'h8) begin
            n_fail++; $display("FAIL w1c_race_pending rdata=%h want 00000008", bus.rdata); end
        wr(BASE + 32'h80, 32'h8);
        rd(BASE + 32'h80);
        n_cmp++; if (bus.rdata !== 32'h0 || irq_o !== 1'b0) begin
            n_fail++; $display("FAIL w1c_clear rdata=%h irq=%b want 0/0", bus.rdata, irq_o); end
    endtask

    task automatic test_level();
        wr(BASE + 32'h14, 32'h3);
        src[5] = 1'b1; tick(); tick();
        wr(BASE + 32'h80, 32'h20);
        rd(BASE + 32'h80);
        n_cmp++; if (bus.rdata !== 32'h20) begin
            n_fail++; $display("FAIL level_w1c_ignored rdata=%h want 00000020", bus.rdata); end
        src[5] = 1'b0; tick();
        n_cmp++; if (irq_o !== 1'b1) begin
            n_fail++; $display("FAIL level_irq_hold got %b want 1", irq_o); end
        tick();
        n_cmp++; if (irq_o !== 1'b0) begin
            n_fail++; $display("FAIL level_irq_drop got %b want 0", irq_o); end
        rd(BASE + 32'h80);
        n_cmp++; if (bus.rdata !== 32'h0) begin
            n_fail++; $display("FAIL level_pending_drop rdata=%h want 0", bus.rdata); end
        wr(BASE + 32'h14, 32'h0);
    endtask

    task automatic test_claim();
        wr(BASE + 32'h4, 32'h1);
        wr(BASE + 32'h1C, 32'h1);
        src[1] = 1'b1; src[7] = 1'b1; tick();
        src[1] = 1'b0; src[7] = 1'b0; tick();
        rd(BASE + 32'h84);
        n_cmp++; if (bus.rdata !== 32'h8000_0001) begin
            n_fail++; $display("FAIL claim_ch1 rdata=%h want 80000001", bus.rdata); end
        wr(BASE + 32'h80, 32'h2);
        rd(BASE + 32'h84);
        n_cmp++; if (bus.rdata !== 32'h8000_0007) begin
            n_fail++; $display("FAIL claim_ch7 rdata=%h want 80000007", bus.rdata); end
        wr(BASE + 32'h80, 32'h80);
        rd(BASE + 32'h84);
        n_cmp++; if (bus.rdata !== 32'h0) begin
            n_fail++; $display("FAIL claim_none rdata=%h want 0", bus.rdata); end
    endtask

    task automatic test_unmapped();
        rd(BASE + 32'h88);
        n_cmp++; if (bus.rdata !== 32'h0 || bus.rvalid !== 1'b1 || bus.addr_err !== 1'b1) begin
            n_fail++; $display("FAIL unmapped_88 rdata=%h rvalid=%b err=%b want 0/1/1", bus.rdata, bus.rvalid, bus.addr_err); end
        tick();
        n_cmp++; if (bus.addr_err !== 1'b0) begin
            n_fail++; $display("FAIL err_pulse got %b want 0", bus.addr_err); end
        rd(BASE + 32'h2);
        n_cmp++; if (bus.rdata !== 32'h0 || bus.addr_err !== 1'b1) begin
            n_fail++; $display("FAIL misaligned rdata=%h err=%b want 0/1", bus.rdata, bus.addr_err); end
        bus.wren = 1'b1; bus.addr = BASE + 32'h88; bus.wdata = 32'hFFFF_FFFF; #1;
        n_cmp++; if (bus.wr_sel !== '0) begin
            n_fail++; $display("FAIL wrsel_miss got %h want 0", bus.wr_sel); end
        tick(); bus.wren = 1'b0;
        n_cmp++; if (bus.addr_err !== 1'b1) begin
            n_fail++; $display("FAIL unmapped_write_err got %b want 1", bus.addr_err); end
        bus.wren = 1'b1; bus.rden = 1'b1; bus.addr = BASE + 32'h8C; tick();
        bus.wren = 1'b0; bus.rden = 1'b0;
        n_cmp++; if (bus.addr_err !== 1'b1) begin
            n_fail++; $display("FAIL rdwr_err got %b want 1", bus.addr_err); end
        tick();
        n_cmp++; if (bus.addr_err !== 1'b0) begin
            n_fail++; $display("FAIL rdwr_single_pulse got %b want 0", bus.addr_err); end
        wr(BASE + 32'h84, 32'hFFFF_FFFF);
        n_cmp++; if (bus.addr_err !== 1'b0) begin
            n_fail++; $display("FAIL claim_write_err got %b want 0", bus.addr_err); end
        wr(BASE, 32'h1);
        bus.wren = 1'b1; bus.rden = 1'b1; bus.addr = BASE; bus.wdata = 32'h2; tick();
        bus.wren = 1'b0; bus.rden = 1'b0;
        n_cmp++; if (bus.rdata !== 32'h1) begin
            n_fail++; $display("FAIL same_cycle_old rdata=%h want 00000001", bus.rdata); end
        rd(BASE);
        n_cmp++; if (bus.rdata !== 32'h2) begin
            n_fail++; $display("FAIL same_cycle_new rdata=%h want 00000002", bus.rdata); end
    endtask

    task automatic test_random();
        int             sel;
        logic [NCH:0]   ews;
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 6)       bus.addr = BASE + 32'(4 * $urandom_range(0, NCH - 1));
            else if (sel == 6) bus.addr = BASE + 32'h80;
            else if (sel == 7) bus.addr = BASE + 32'h84;
            else if (sel == 8) bus.addr = BASE + 32'h88 + 32'(4 * $urandom_range(0, 7));
            else               bus.addr = BASE + 32'(4 * $urandom_range(0, NCH - 1)) + 32'($urandom_range(1, 3));
            bus.wren  = ($urandom_range(0, 2) == 0);
            bus.rden  = ($urandom_range(0, 1) == 0);
            bus.wdata = (sel == 6) ? ($urandom & $urandom) : $urandom;
            src       = src ^ NCH'($urandom & $urandom);
            #1;
            ews = exp_wrsel(bus.wren, bus.addr);
            n_cmp++; if (bus.wr_sel !== ews) begin
                n_fail++; $display("FAIL rnd_wrsel i=%0d got %h want %h", i, bus.wr_sel, ews); end
            tick();
            n_cmp++; if (bus.rvalid !== m_rvalid || bus.addr_err !== m_err || irq_o !== m_irq) begin
                n_fail++; $display("FAIL rnd_flags i=%0d rvalid=%b err=%b irq=%b want %b/%b/%b",
                                   i, bus.rvalid, bus.addr_err, irq_o, m_rvalid, m_err, m_irq); end
            if (m_rvalid) begin
                n_cmp++; if (bus.rdata !== m_rdata) begin
                    n_fail++; $display("FAIL rnd_rdata i=%0d got %h want %h", i, bus.rdata, m_rdata); end
            end
        end
        bus.wren = 1'b0; bus.rden = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; src = '0;
        bus.wren = 1'b0; bus.rden = 1'b0; bus.addr = '0; bus.wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_edge();
        test_w1c_race();
        test_level();
        test_claim();
        test_unmapped();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
